rom_port_arbiter: RTL

//  Shares the single program/data ROM port (Ma/Md, 16b async ROM, ~70ns access) between two

---
 rtl/rom_port_arbiter.sv | 97 +++++++++
 1 files changed

// File: rtl/rom_port_arbiter.sv
// Two-port arbiter for a single asynchronous ROM: round-robin between instruction
// fetch and load unit, registered ROM address, programmable wait states before capture.
module rom_port_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ack,
    output logic [DATA_W-1:0] f_data,
    input  logic              l_req,
    input  logic [ADDR_W-1:0] l_addr,
    output logic              l_ack,
    output logic [DATA_W-1:0] l_data,
    output logic [ADDR_W-1:0] Ma,
    input  logic [DATA_W-1:0] Md,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    typedef enum logic {FETCH, LOAD} grant_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t            state, state_nx;
    grant_t            last_grant, grant_nx;
    logic [3:0]        cnt, cnt_nx;
    logic [ADDR_W-1:0] ma_nx;
    logic              cap_f, cap_l;

    // NOTE: every output of this block gets a default first, so no path leaves a
    // variable unassigned and no latch is inferred.
    always_comb begin
        state_nx = state;
        grant_nx = last_grant;
        cnt_nx   = cnt;
        ma_nx    = Ma;
        cap_f    = 1'b0;
        cap_l    = 1'b0;
        case (state)
            IDLE: begin
                if (f_req || l_req) begin
                    if (f_req && l_req)
                        grant_nx = (last_grant == FETCH) ? LOAD : FETCH;
                    else if (f_req)
                        grant_nx = FETCH;
                    else
                        grant_nx = LOAD;
                    ma_nx    = (grant_nx == FETCH) ? f_addr : l_addr;
                    cnt_nx   = WAIT_INIT;
                    state_nx = ACCESS;
                end
            end
            ACCESS: begin
                // last_grant already holds the current grant while the access runs
                if (cnt != 4'd0) begin
                    cnt_nx = cnt - 4'd1;
                end else begin
                    cap_f    = (last_grant == FETCH);
                    cap_l    = (last_grant == LOAD);
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= LOAD;
            cnt        <= 4'd0;
            Ma         <= '0;
            f_data     <= '0;
            l_data     <= '0;
        end else begin
            state      <= state_nx;
            last_grant <= grant_nx;
            cnt        <= cnt_nx;
            Ma         <= ma_nx;
            if (cap_f) f_data <= Md;
            if (cap_l) l_data <= Md;
        end
    end

    // Acks decode straight from registered state, so they are glitch-free single pulses
    assign f_ack = (state == DONE) && (last_grant == FETCH);
    assign l_ack = (state == DONE) && (last_grant == LOAD);
    assign busy  = (state != IDLE);

endmodule
